// File: rtl/sha_arbiter.sv
// Round-robin front end that time-shares one SHA-256 compression core among
// N_REQ block sources, returning each digest tagged with its requester index.
module sha_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned PADDED_SIZE = 512,
  parameter int unsigned MAX_CYCLES  = 255,
  parameter int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*PADDED_SIZE-1:0] req_block,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [255:0]                 resp_hash,
  output logic                         resp_err,
  output logic                         core_rst,
  output logic [PADDED_SIZE-1:0]       core_padded,
  input  logic                         core_done,
  input  logic [255:0]                 core_hash,
  output logic                         busy
);

  localparam int unsigned CNT_W  = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned SCAN_W = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic [SCAN_W-1:0] scan;
  logic              timeout_c;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = SCAN_W'(rr_ptr) + SCAN_W'(i);
      if (scan >= SCAN_W'(N_REQ)) begin
        scan = scan - SCAN_W'(N_REQ);
      end
      if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state == S_IDLE) && !rst && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign timeout_c = (wait_cnt == CNT_W'(MAX_CYCLES - 1));
  assign resp_id   = grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus state-decoded outputs; core held in reset until WAIT.
  always_comb begin
    state_nx   = state;
    core_rst   = 1'b1;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (gnt_found) begin
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        core_rst = 1'b0;
        if (core_done || timeout_c) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        core_rst   = 1'b0;
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (rst) begin
      core_rst = 1'b1;
    end
  end

  // Transaction datapath: block latch, grant bookkeeping, wait timer, digest capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      core_padded <= '0;
      resp_hash   <= '0;
      resp_err    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            core_padded <= req_block[32'(gnt_idx)*PADDED_SIZE +: PADDED_SIZE];
            grant_id    <= gnt_idx;
            rr_ptr      <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (core_done) begin
            resp_hash <= core_hash;
            resp_err  <= 1'b0;
          end else if (timeout_c) begin
            resp_hash <= '0;
            resp_err  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_arbiter.sv
// Bench for sha_arbiter: behavioural SHA-256 core model, directed vector table,
// hand sequences for reset/timeout corners, and randomized round-robin traffic.
module tb_sha_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned PS   = 512;
  localparam int unsigned MAXC = 16;
  localparam int unsigned IDW  = 2;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N*PS-1:0]    req_block;
  logic [N-1:0]       req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [255:0]       resp_hash;
  logic               resp_err;
  logic               core_rst;
  logic [PS-1:0]      core_padded;
  logic               core_done = 1'b0;
  logic [255:0]       core_hash = '0;
  logic               busy;

  logic [PS-1:0]      blocks [N];
  int                 core_lat  = 0;
  bit                 core_hang = 1'b0;
  int                 core_cnt  = 0;
  int                 ref_ptr   = 0;
  int                 n_cmp     = 0;
  int                 n_err     = 0;

  typedef struct {
    logic [3:0] vmask;
    int         exp_id;
    int         lat;
    bit         hang;
    int         bp;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  assign req_block = {blocks[3], blocks[2], blocks[1], blocks[0]};

  sha_arbiter #(
    .N_REQ       (N),
    .PADDED_SIZE (PS),
    .MAX_CYCLES  (MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_block   (req_block),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_hash   (resp_hash),
    .resp_err    (resp_err),
    .core_rst    (core_rst),
    .core_padded (core_padded),
    .core_done   (core_done),
    .core_hash   (core_hash),
    .busy        (busy)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single-block SHA-256 compression from the initial hash values.
  function automatic logic [255:0] sha256(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    v = h;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    return {h[0] + v[0], h[1] + v[1], h[2] + v[2], h[3] + v[3],
            h[4] + v[4], h[5] + v[5], h[6] + v[6], h[7] + v[7]};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  // Reference grant: nearest requesting index going around the ring from ptr.
  function automatic int pick(input logic [3:0] m, input int p);
    for (int d = 0; d < 4; d++) begin
      if (m[(p + d) % 4]) return (p + d) % 4;
    end
    return -1;
  endfunction

  // Core model: counts cycles out of reset, raises done after core_lat, holds result.
  always @(posedge clk) begin
    if (core_rst) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
      core_hash <= {8{32'($urandom())}};
    end else begin
      core_cnt <= core_cnt + 1;
      if (!core_hang && !core_done && core_cnt == core_lat) begin
        core_done <= 1'b1;
        core_hash <= sha256(core_padded);
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full transaction starting from an IDLE cycle; ends in the following IDLE cycle.
  task automatic run_txn(input logic [3:0] vmask, input int exp_id, input int lat,
                         input bit hang, input int bp);
    int           n;
    int           exp_n;
    bit           rst_low;
    logic [255:0] hexp;
    hexp  = hang ? 256'h0 : ((exp_id == 2) ? ABC_DIGEST : sha256(blocks[exp_id]));
    exp_n = hang ? int'(MAXC) + 2 : lat + 4;
    core_lat   = lat;
    core_hang  = hang;
    req_valid  = vmask;
    resp_ready = 1'b0;
    #1;
    chki("grant_onehot", int'(req_ready), 1 << exp_id);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_core_rst", core_rst, 1'b1);
    @(posedge clk); #2;
    chk1("launch_core_rst", core_rst, 1'b1);
    chki("launch_req_ready", int'(req_ready), 0);
    chk1("launch_busy", busy, 1'b1);
    chk1("launch_padded", core_padded == blocks[exp_id], 1'b1);
    n = 1;
    rst_low = 1'b1;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #2;
      n++;
      if (!resp_valid && core_rst) rst_low = 1'b0;
    end
    chk1("wait_core_rst_low", rst_low, 1'b1);
    chki("resp_latency", n, exp_n);
    chk1("resp_valid", resp_valid, 1'b1);
    chki("resp_id", int'(resp_id), exp_id);
    chk1("resp_err", resp_err, hang);
    chkv("resp_hash", resp_hash, hexp);
    chk1("resp_core_rst", core_rst, 1'b0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #2;
      chk1("bp_valid", resp_valid, 1'b1);
      chk1("bp_busy", busy, 1'b1);
      chki("bp_req_ready", int'(req_ready), 0);
      chki("bp_id", int'(resp_id), exp_id);
      chkv("bp_hash", resp_hash, hexp);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    #1;
    chk1("post_busy", busy, 1'b0);
    chk1("post_valid", resp_valid, 1'b0);
    ref_ptr = (exp_id + 1) % 4;
  endtask

  initial begin
    logic [3:0] m;
    int         e;
    bit         saw;

    for (int i = 0; i < 8; i++) tbl[i] = '{4'hf, i % 4, i, 1'b0, 0};
    tbl[8]  = '{4'b0100, 2, 5,  1'b0, 0};
    tbl[9]  = '{4'b0001, 0, 2,  1'b0, 10};
    tbl[10] = '{4'b0010, 1, 0,  1'b0, 0};
    tbl[11] = '{4'b1010, 3, 1,  1'b0, 1};
    tbl[12] = '{4'b1010, 1, 7,  1'b0, 0};
    tbl[13] = '{4'b1111, 2, 0,  1'b1, 2};
    tbl[14] = '{4'b1111, 3, 4,  1'b0, 0};
    tbl[15] = '{4'b0001, 0, 14, 1'b0, 0};

    for (int b = 0; b < 4; b++) blocks[b] = rand512();
    blocks[2] = ABC_BLOCK;

    rst        = 1'b1;
    req_valid  = 4'hf;
    resp_ready = 1'b0;
    @(posedge clk); #2;
    chki("rst_req_ready", int'(req_ready), 0);
    chk1("rst_core_rst", core_rst, 1'b1);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'h0;
    #1;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_resp_valid", resp_valid, 1'b0);
    chk1("reset_resp_err", resp_err, 1'b0);
    chki("reset_resp_id", int'(resp_id), 0);
    chkv("reset_resp_hash", resp_hash, 256'h0);
    chk1("reset_padded", core_padded == '0, 1'b1);
    chk1("reset_core_rst", core_rst, 1'b1);
    chki("idle_no_req", int'(req_ready), 0);

    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i].vmask, tbl[i].exp_id, tbl[i].lat, tbl[i].hang, tbl[i].bp);
    end

    // Reset while WAIT: abort with no response, scan restarts from requester 0.
    req_valid = 4'b0001;
    core_hang = 1'b1;
    #1;
    chki("mid_grant", int'(req_ready), 1);
    @(posedge clk); #2;
    req_valid = 4'b0000;
    repeat (4) @(posedge clk);
    #2;
    chk1("mid_busy", busy, 1'b1);
    chk1("mid_core_rst_low", core_rst, 1'b0);
    rst = 1'b1;
    #1;
    chk1("mid_rst_core_rst", core_rst, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk1("mid_after_busy", busy, 1'b0);
    chk1("mid_after_valid", resp_valid, 1'b0);
    chk1("mid_after_core_rst", core_rst, 1'b1);
    chk1("mid_after_padded", core_padded == '0, 1'b1);
    chkv("mid_after_hash", resp_hash, 256'h0);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      if (resp_valid) saw = 1'b1;
    end
    chk1("mid_no_resp", saw, 1'b0);
    ref_ptr = 0;
    run_txn(4'b1110, 1, 3, 1'b0, 0);

    for (int t = 0; t < 30; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int b = 0; b < 4; b++) begin
        if (b != 2) blocks[b] = rand512();
      end
      e = pick(m, ref_ptr);
      run_txn(m, e, int'($urandom_range(0, 14)), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
